// File: rtl/requant_pkg.sv
// Shared types and constants for the requantiser: rounding-mode encoding and
// the stochastic-rounding LFSR definition (x^16+x^14+x^13+x^11+1, right-shifting).
package requant_pkg;

  typedef enum logic [1:0] {
    TRUNC   = 2'd0,
    PSEUDO  = 2'd1,
    HALF_UP = 2'd2,
    STOCH   = 2'd3
  } rnd_mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 0,2,3,5 of a right-shifting register realise taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/requant_round_pipe_if.sv
// Beat-level bus of the requantiser: per-beat config, input stream and output stream.
// The slave modport is the requantiser's view; master is the driver/sink side.
interface requant_round_pipe_if #(
  parameter int LANES     = 2,
  parameter int WID_IN    = 32,
  parameter int WID_OUT   = 8,
  parameter int WID_SHCFG = 5
);
  logic [WID_SHCFG-1:0]       cfg_shift;
  logic [1:0]                 cfg_mode;
  logic                       cfg_sat;
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*WID_IN-1:0]    in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*WID_OUT-1:0]   out_data;
  logic                       ovf_flag;

  modport master (
    output cfg_shift, cfg_mode, cfg_sat, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf_flag
  );

  modport slave (
    input  cfg_shift, cfg_mode, cfg_sat, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf_flag
  );
endinterface

// File: rtl/requant_lane.sv
// One lane, purely combinational: stage-1 shift and round-bit select from the raw
// accumulator, and stage-2 add/saturate from the registered base and round bit.
module requant_lane
  import requant_pkg::*;
#(
  parameter int WID_IN    = 32,
  parameter int WID_OUT   = 8,
  parameter int WID_SHCFG = 5
) (
  input  logic [WID_IN-1:0]    x,
  input  logic [WID_SHCFG-1:0] s_eff,
  input  rnd_mode_e            mode,
  input  logic [15:0]          rnd_thr,
  output logic [WID_IN-1:0]    base,
  output logic                 r,
  input  logic [WID_IN-1:0]    q_base,
  input  logic                 q_r,
  input  logic                 sat,
  output logic [WID_OUT-1:0]   y,
  output logic                 ovf
);
  localparam logic [WID_IN-1:0] ONES = '1;
  localparam logic signed [WID_IN:0] QMAX =
    $signed({{(WID_IN-WID_OUT+2){1'b0}}, {(WID_OUT-1){1'b1}}});
  localparam logic signed [WID_IN:0] QMIN = ~QMAX;

  logic [WID_SHCFG-1:0] h, s_m1;
  logic [WID_IN-1:0]    d, d_hi, d_lo;
  logic [15:0]          d_top;
  logic signed [WID_IN:0] q;
  logic                 ovf_hi, ovf_lo;

  assign base  = $signed(x) >>> s_eff;
  assign d     = x & ~(ONES << s_eff);
  assign h     = s_eff >> 1;
  assign s_m1  = s_eff - WID_SHCFG'(1);
  assign d_hi  = d >> h;
  assign d_lo  = d & ~(ONES << h);
  // Discarded bits left-aligned into a 16-bit fraction for the stochastic compare.
  assign d_top = 16'({d, 16'h0000} >> s_eff);

  always_comb begin
    r = 1'b0;
    if (s_eff != '0) begin
      case (mode)
        PSEUDO:  r = d_hi > d_lo;
        HALF_UP: r = x[s_m1];
        STOCH:   r = d_top > rnd_thr;
        default: r = 1'b0;
      endcase
    end
  end

  assign q      = $signed({q_base[WID_IN-1], q_base}) + $signed({{WID_IN{1'b0}}, q_r});
  assign ovf_hi = q > QMAX;
  assign ovf_lo = q < QMIN;
  assign ovf    = ovf_hi || ovf_lo;

  always_comb begin
    y = q[WID_OUT-1:0];
    if (sat && ovf_hi)      y = QMAX[WID_OUT-1:0];
    else if (sat && ovf_lo) y = QMIN[WID_OUT-1:0];
  end
endmodule

// File: rtl/requant_round_pipe.sv
// Two-stage elastic requantiser (latency 2, 1 beat/cycle); stalls propagate back via in_ready.
// REQUANT_STOCH_EN enables stochastic rounding in mode 3; otherwise mode 3 truncates.
module requant_round_pipe
  import requant_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int WID_IN    = 32,
  parameter int WID_OUT   = 8,
  parameter int WID_SHCFG = 5
) (
  input  logic clk,
  input  logic rst,
  requant_round_pipe_if.slave bus
);
  localparam logic [WID_SHCFG-1:0] SHIFT_MAX = WID_SHCFG'(WID_IN-1);

  logic                       s1_v, s2_v, s1_adv, in_fire;
  logic [WID_SHCFG-1:0]       s_eff;
  rnd_mode_e                  mode_eff;
  logic [15:0]                rnd_thr;
  logic [WID_IN-1:0]          base_c  [LANES];
  logic [WID_IN-1:0]          s1_base [LANES];
  logic [LANES-1:0]           r_c, s1_r, ovf_c;
  logic                       s1_sat;
  logic [LANES*WID_OUT-1:0]   y_c, out_q;
  logic                       ovf_q;

  assign s1_adv       = !s2_v || bus.out_ready;
  assign bus.in_ready = !s1_v || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign s_eff        = (bus.cfg_shift > SHIFT_MAX) ? SHIFT_MAX : bus.cfg_shift;

`ifdef REQUANT_STOCH_EN
  logic [15:0] lfsr;

  // One LFSR value per accepted beat, shared by all lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lfsr <= LFSR_SEED;
    else if (in_fire) lfsr <= lfsr_step(lfsr);
  end

  assign mode_eff = rnd_mode_e'(bus.cfg_mode);
  assign rnd_thr  = lfsr;
`else
  assign mode_eff = (rnd_mode_e'(bus.cfg_mode) == STOCH) ? TRUNC : rnd_mode_e'(bus.cfg_mode);
  assign rnd_thr  = '0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .WID_IN(WID_IN), .WID_OUT(WID_OUT), .WID_SHCFG(WID_SHCFG)
    ) u_lane (
      .x      (bus.in_data[i*WID_IN +: WID_IN]),
      .s_eff  (s_eff),
      .mode   (mode_eff),
      .rnd_thr(rnd_thr),
      .base   (base_c[i]),
      .r      (r_c[i]),
      .q_base (s1_base[i]),
      .q_r    (s1_r[i]),
      .sat    (s1_sat),
      .y      (y_c[i*WID_OUT +: WID_OUT]),
      .ovf    (ovf_c[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_base <= '{default: '0};
      s1_r    <= '0;
      s1_sat  <= 1'b0;
    end else if (bus.in_ready) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_base <= base_c;
        s1_r    <= r_c;
        s1_sat  <= bus.cfg_sat;
      end
    end
  end

  // Output register only loads when free or draining, so data holds during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v  <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (s1_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_q <= y_c;
        ovf_q <= |ovf_c;
      end
    end
  end

  assign bus.out_valid = s2_v;
  assign bus.out_data  = out_q;
  assign bus.ovf_flag  = ovf_q;
endmodule

// File: tb/tb_requant_round_pipe.sv
// Directed and random beats against an arithmetic reference model and scoreboard.
module tb_requant_round_pipe;
`ifdef REQUANT_STOCH_EN
  localparam bit STOCH_EN = 1'b1;
`else
  localparam bit STOCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  requant_round_pipe_if bus();
  requant_round_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          total = 0, bad = 0, cyc = 0, emitted = 0;
  int          hit0 = 0, hit1 = 0, e0, guard;
  bit          stoch_phase = 0, acc_ok;
  logic [15:0] m_lfsr = 16'hACE1;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_ovf;
  logic [8:0]  l0, l1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Returns {ovf, y}: floor shift, round bit by mode, then add and range check.
  function automatic logic [8:0] ref_lane(input logic [31:0] x, input int s, input int mode,
                                          input bit sat, input logic [15:0] thr);
    longint xs, base, d, p, hi, lo, top, q;
    int     se, h;
    bit     r, ov;
    logic [7:0] y;
    xs   = longint'($signed(x));
    se   = (s > 31) ? 31 : s;
    p    = longint'(1) << se;
    base = xs >>> se;
    d    = xs - base * p;
    r    = 1'b0;
    if (se > 0) begin
      case (mode)
        1: begin
          h  = se / 2;
          hi = d / (longint'(1) << h);
          lo = d % (longint'(1) << h);
          r  = (hi > lo);
        end
        2: r = (d >= p / 2);
        3: begin
          top = (se >= 16) ? d / (longint'(1) << (se - 16)) : d * (longint'(1) << (16 - se));
          r   = STOCH_EN && (top > longint'(thr));
        end
        default: r = 1'b0;
      endcase
    end
    q  = base + longint'(r);
    ov = (q > 127) || (q < -128);
    if (sat && q > 127)       y = 8'h7F;
    else if (sat && q < -128) y = 8'h80;
    else                      y = q[7:0];
    return {ov, y};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: predicts on acceptance, checks on emission, polices hold and in_ready.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_lfsr = 16'hACE1;
      prev_stall = 0;
    end else begin
      chk("in_ready", bus.in_ready, !(sbq.size() == 2 && !bus.out_ready));
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", {bus.ovf_flag, bus.out_data}, {prev_ovf, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("ovf_flag", bus.ovf_flag, e.ovf);
          chk("latency_min", (cyc - e.acc) >= 2, 1);
          emitted++;
          if (stoch_phase && bus.out_data[7:0] == 8'h11)  hit0++;
          if (stoch_phase && bus.out_data[15:8] == 8'h11) hit1++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_ovf   = bus.ovf_flag;
      if (bus.in_valid && bus.in_ready) begin
        l0 = ref_lane(bus.in_data[31:0],  bus.cfg_shift, bus.cfg_mode, bus.cfg_sat, m_lfsr);
        l1 = ref_lane(bus.in_data[63:32], bus.cfg_shift, bus.cfg_mode, bus.cfg_sat, m_lfsr);
        sbq.push_back('{data: {l1[7:0], l0[7:0]}, ovf: l0[8] | l1[8], acc: cyc});
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  end

  task automatic send_one(input logic [63:0] data, input logic [4:0] s, input logic [1:0] mode,
                          input bit sat, input logic [15:0] exp_data, input bit exp_ovf,
                          input string tag);
    int n;
    bus.in_data   = data;
    bus.cfg_shift = s;
    bus.cfg_mode  = mode;
    bus.cfg_sat   = sat;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 8);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_data"}, bus.out_data, exp_data);
    chk({tag, "_ovf"}, bus.ovf_flag, exp_ovf);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.cfg_shift = '0;
    bus.cfg_mode = '0;   bus.cfg_sat = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ovf", bus.ovf_flag, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send_one(64'h03000FFF_05001000, 5'd24, 2'd1, 1'b1, 16'h0306, 1'b0, "pseudo");
    send_one(64'h00000000_7F800000, 5'd24, 2'd2, 1'b1, 16'h007F, 1'b1, "halfup_sat");
    send_one(64'h00000000_7F800000, 5'd24, 2'd2, 1'b0, 16'h0080, 1'b1, "halfup_wrap");
    send_one(64'h00000000_FFFFFF80, 5'd8,  2'd0, 1'b1, 16'h00FF, 1'b0, "trunc_neg");
    send_one(64'h00000000_FFFFFF80, 5'd8,  2'd2, 1'b1, 16'h0000, 1'b0, "halfup_neg");
    send_one(64'h00000000_00000042, 5'd0,  2'd2, 1'b1, 16'h0042, 1'b0, "s0");
    send_one(64'h00000000_00000100, 5'd0,  2'd2, 1'b1, 16'h007F, 1'b1, "s0_sat");
    send_one(64'h40000000_80000000, 5'd31, 2'd2, 1'b1, 16'h01FF, 1'b0, "s31");
`ifndef REQUANT_STOCH_EN
    send_one(64'h00000000_FFFFFF80, 5'd8,  2'd3, 1'b1, 16'h00FF, 1'b0, "mode3_trunc");
`endif

    // 16 back-to-back random beats, out_ready toggling every cycle
    e0 = emitted;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = {32'($signed($urandom) >>> $urandom_range(0, 28)),
                       32'($signed($urandom) >>> $urandom_range(0, 28))};
      bus.cfg_shift = 5'($urandom_range(0, 31));
      bus.cfg_mode  = 2'($urandom_range(0, 3));
      bus.cfg_sat   = 1'($urandom_range(0, 1));
      guard = 0;
      do begin
        @(negedge clk);
        acc_ok = bus.in_ready;
        @(posedge clk);
        #1 bus.out_ready = !bus.out_ready;
        guard++;
      end while (!acc_ok && guard < 20);
      chk("bb_accept", acc_ok, 1);
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while ((sbq.size() != 0 || bus.out_valid) && guard < 50) begin
      @(posedge clk);
      #1 bus.out_ready = !bus.out_ready;
      guard++;
    end
    chk("bb_emitted", emitted - e0, 16);
    chk("bb_drained", sbq.size(), 0);

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.cfg_shift = 5'd8; bus.cfg_mode = 2'd0; bus.cfg_sat = 1'b1;
    bus.in_data   = 64'h00000500_00000400;
    @(posedge clk);
    #1 bus.in_data = 64'h00000700_00000600;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_data", bus.out_data, 0);
    chk("rst_async_ovf", bus.ovf_flag, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ghost", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_one(64'h00000000_00000300, 5'd8, 2'd0, 1'b1, 16'h0003, 1'b0, "post_rst");

`ifdef REQUANT_STOCH_EN
    e0 = emitted;
    stoch_phase   = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = 64'h00001000_000010FF;
    bus.cfg_shift = 5'd8; bus.cfg_mode = 2'd3; bus.cfg_sat = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (256) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    guard = 0;
    while ((sbq.size() != 0 || bus.out_valid) && guard < 20) begin
      @(posedge clk);
      #1 guard++;
    end
    stoch_phase = 1'b0;
    chk("stoch_count", emitted - e0, 256);
    chk("stoch_d00_never", hit1, 0);
    chk("stoch_dff_range", (hit0 >= 240 && hit0 <= 256), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
